// File: rtl/accum_request_sequencer_if.sv
// Request-sequencer bus: capture controls and pixel stream in, accumulator
// request stream and run status out.
interface accum_request_sequencer_if #(
    parameter int DEPTH     = 76800,
    parameter int BITS      = 8,
    parameter int LUM_WIDTH = 8
);
    localparam int AW  = $clog2(DEPTH);
    localparam int FCW = $clog2(BITS + 1);

    logic                 start_in;
    logic                 abort_in;
    logic                 pixel_valid_in;
    logic                 frame_start_in;
    logic [LUM_WIDTH-1:0] pixel_lum_in;
    logic [LUM_WIDTH-1:0] threshold_in;

    logic [AW-1:0]        addr_out;
    logic                 summand_out;
    logic                 request_type_out;
    logic                 request_valid_out;
    logic                 busy_out;
    logic [FCW-1:0]       frame_count_out;
    logic                 done_out;
    logic                 frame_err_out;

    modport slave (
        input  start_in, abort_in, pixel_valid_in, frame_start_in,
               pixel_lum_in, threshold_in,
        output addr_out, summand_out, request_type_out, request_valid_out,
               busy_out, frame_count_out, done_out, frame_err_out
    );

    modport master (
        output start_in, abort_in, pixel_valid_in, frame_start_in,
               pixel_lum_in, threshold_in,
        input  addr_out, summand_out, request_type_out, request_valid_out,
               busy_out, frame_count_out, done_out, frame_err_out
    );
endinterface

// File: rtl/accum_request_sequencer.sv
// Turns BITS thresholded frames into accumulator WRITE requests, then sweeps
// the accumulator with one READ per address and pulses done.
module accum_request_sequencer #(
    parameter int DEPTH     = 76800,
    parameter int BITS      = 8,
    parameter int LUM_WIDTH = 8
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    accum_request_sequencer_if.slave bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int FCW = $clog2(BITS + 1);
    localparam logic [AW-1:0]  LAST_ADDR  = AW'(DEPTH - 1);
    localparam logic [FCW-1:0] LAST_FRAME = FCW'(BITS);

    typedef enum logic [1:0] {IDLE, WAIT_FRAME, CAPTURE, READOUT} state_t;
    typedef enum logic {READ = 1'b0, WRITE = 1'b1} accum_request_t;

    state_t         r_state;
    logic [AW-1:0]  r_cnt;
    logic [AW-1:0]  r_addr;
    logic           r_summand;
    accum_request_t r_type;
    logic           r_valid;
    logic           r_busy;
    logic [FCW-1:0] r_fcount;
    logic           r_done;
    logic           r_err;
    logic           r_rd_end;

    logic           w_take;
    logic           w_short;
    logic [AW-1:0]  w_waddr;
    logic           w_last;
    logic [FCW-1:0] w_fcount_inc;
    logic           w_summand;

    // A frame-start pixel always lands on address 0, whether it opens a frame
    // or truncates the current one.
    assign w_take       = bus.pixel_valid_in &&
                          ((r_state == CAPTURE) ||
                           ((r_state == WAIT_FRAME) && bus.frame_start_in));
    assign w_short      = (r_state == CAPTURE) && bus.pixel_valid_in &&
                          bus.frame_start_in && (r_cnt != '0);
    assign w_waddr      = ((r_state == CAPTURE) && !bus.frame_start_in) ? r_cnt : '0;
    assign w_last       = (w_waddr == LAST_ADDR);
    assign w_fcount_inc = r_fcount + 1'b1;
    assign w_summand    = (bus.pixel_lum_in >= bus.threshold_in);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_summand <= 1'b0;
            r_type    <= READ;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_fcount  <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_rd_end  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            if (bus.abort_in) begin
                r_state  <= IDLE;
                r_busy   <= 1'b0;
                r_rd_end <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bus.start_in) begin
                            r_state  <= WAIT_FRAME;
                            r_busy   <= 1'b1;
                            r_fcount <= '0;
                            r_err    <= 1'b0;
                        end
                    end
                    WAIT_FRAME, CAPTURE: begin
                        if (w_take) begin
                            r_addr    <= w_waddr;
                            r_summand <= w_summand;
                            r_type    <= WRITE;
                            r_valid   <= 1'b1;
                            if (w_short) r_err <= 1'b1;
                            if (w_last) begin
                                r_cnt    <= '0;
                                r_fcount <= w_fcount_inc;
                                r_state  <= (w_fcount_inc == LAST_FRAME) ? READOUT : WAIT_FRAME;
                            end else begin
                                r_cnt   <= w_waddr + 1'b1;
                                r_state <= CAPTURE;
                            end
                        end
                    end
                    READOUT: begin
                        // r_rd_end marks the cycle after the last READ, which carries done.
                        if (r_rd_end) begin
                            r_rd_end <= 1'b0;
                            r_done   <= 1'b1;
                            r_busy   <= 1'b0;
                            r_state  <= IDLE;
                        end else begin
                            r_addr    <= r_cnt;
                            r_summand <= 1'b0;
                            r_type    <= READ;
                            r_valid   <= 1'b1;
                            if (r_cnt == LAST_ADDR) begin
                                r_cnt    <= '0;
                                r_rd_end <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.addr_out          = r_addr;
    assign bus.summand_out       = r_summand;
    assign bus.request_type_out  = r_type;
    assign bus.request_valid_out = r_valid;
    assign bus.busy_out          = r_busy;
    assign bus.frame_count_out   = r_fcount;
    assign bus.done_out          = r_done;
    assign bus.frame_err_out     = r_err;
endmodule

// File: doc/accum_request_sequencer.md
ACCUM_REQUEST_SEQUENCER -- requirements
Module: accum_request_sequencer

Interface
REQ-001 Parameter DEPTH, default 76800: pixels per frame, equal to the downstream accumulator RAM depth.
REQ-002 Parameter BITS, default 8: frames captured per code, equal to the downstream accumulator WIDTH.
REQ-003 Parameter LUM_WIDTH, default 8: pixel luminance width.
REQ-004 Port list, one per line:
- clk_in  input  1  sole clock; all logic on the rising edge.
- rst_in  input  1  reset, asynchronous, active-low.
- start_in  input  1  single-cycle pulse that begins a capture run.
- abort_in  input  1  synchronous abort to IDLE.
- pixel_valid_in  input  1  pixel qualifier.
- frame_start_in  input  1  marks the first pixel of a frame; meaningful only with pixel_valid_in.
- pixel_lum_in  input  LUM_WIDTH  pixel luminance.
- threshold_in  input  LUM_WIDTH  on/off threshold.
- addr_out  output  $clog2(DEPTH)  request address.
- summand_out  output  1  bit to shift in.
- request_type_out  output  1  accum_request_t, READ=0 or WRITE=1.
- request_valid_out  output  1  request qualifier.
- busy_out  output  1  high when not IDLE.
- frame_count_out  output  $clog2(BITS+1)  completed frames in the current run.
- done_out  output  1  single-cycle pulse at the end of the readout sweep.
- frame_err_out  output  1  sticky short-frame flag.

Function
REQ-005 States: IDLE, WAIT_FRAME, CAPTURE, READOUT.
REQ-006 All outputs are registered; a request appears exactly 1 cycle after the input cycle that causes it.
REQ-007 IDLE: start_in=1 -> WAIT_FRAME; frame_count_out <= 0; frame_err_out <= 0. start_in is ignored in every other state.
REQ-008 WAIT_FRAME: pixel_valid_in && frame_start_in -> CAPTURE. That pixel is processed as address 0 in the same cycle. Any other pixels are ignored.
REQ-009 CAPTURE: each pixel_valid_in issues a WRITE. The pixel counter increments after each pixel.
- addr_out = pixel counter.
- summand_out = (pixel_lum_in >= threshold_in), unsigned compare.
- request_valid_out = 1.
REQ-010 CAPTURE: cycles without pixel_valid_in give request_valid_out=0. addr_out, summand_out and request_type_out hold their last values.
REQ-011 Writing address DEPTH-1 completes a frame:
- frame_count_out increments and the counter wraps to 0.
- If frame_count_out reaches BITS, the next state is READOUT; otherwise it is WAIT_FRAME.
REQ-012 frame_start_in with pixel_valid_in in CAPTURE at counter != 0 is a short frame:
- frame_err_out <= 1.
- That pixel is written as address 0 and the counter becomes 1.
- frame_count_out is unchanged.
REQ-013 frame_start_in at counter == 0 in CAPTURE is normal.
REQ-014 READOUT: issues READ requests for addresses 0 to DEPTH-1, one per consecutive cycle, with request_valid_out=1 and summand_out=0. Pixel inputs are ignored and there is no stall.
REQ-015 READOUT: the cycle after the address DEPTH-1 request, done_out=1 for one cycle, request_valid_out=0, and the state returns to IDLE.
REQ-016 abort_in=1 in any state:
- Next state is IDLE and request_valid_out=0 on the next cycle.
- No done_out is produced.
- frame_count_out and frame_err_out hold their values.
REQ-017 abort_in has priority over start_in and over the pixel inputs in the same cycle.
REQ-018 Simultaneous final-pixel write and short-frame condition cannot occur; REQ-012 takes precedence if frame_start_in is asserted.
REQ-019 busy_out=0 only in IDLE.

Reset
REQ-020 rst_in=0 asynchronously forces:
- state IDLE and pixel counter 0.
- addr_out=0, summand_out=0, request_type_out=READ, request_valid_out=0.
- busy_out=0, frame_count_out=0, done_out=0, frame_err_out=0.
REQ-021 Reset mid-run discards the run. No further requests are issued until a new start_in after reset is released.

Verification
REQ-022 Verification uses DEPTH=4, BITS=2 and threshold_in=128.
REQ-023 Nominal run: start, then 2 frames with lum {200,10,128,127} and {0,255,0,255} -> WRITE summands 1,0,1,0 then 0,1,0,1 at addr 0..3, each one cycle after its pixel. Then READ at addr 0..3 on 4 consecutive cycles, then done_out pulse, busy_out=0.
REQ-024 Pixels before start, or pixels in WAIT_FRAME without frame_start_in -> request_valid_out stays 0 and frame_count_out=0.
REQ-025 Gapped pixels: valid on every third cycle -> one WRITE per pixel, valid low in between, address sequence 0,1,2,3 unbroken.
REQ-026 Short frame: frame_start_in at pixel index 2 -> frame_err_out=1, that pixel written to addr 0, frame_count_out stays 0 until the new frame completes.
REQ-027 abort_in in READOUT at addr 1 -> no further requests, no done_out, busy_out=0 on the next cycle. A new start_in runs normally with frame_err_out cleared.
REQ-028 rst_in low during CAPTURE at addr 2 -> all outputs reach their reset values immediately, without waiting for a clock edge. Pixels after release produce no requests.
